// File: rtl/comparator_search_ctrl.sv
// Binary-search initiator for an lt/gt/eq comparator responder.
// Define COMPARATOR_TIMEOUT_EN to abort a probe after TIMEOUT ack-less cycles.
module comparator_search_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_start,
  input  logic             i_w_ack,
  input  logic             i_w_lt,
  input  logic             i_w_gt,
  input  logic             i_w_eq,
  output logic             o_w_req,
  output logic [WIDTH-1:0] o_w_guess,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic             o_w_found,
  output logic             o_w_err,
  output logic [WIDTH-1:0] o_w_result
);

  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] low, low_d;
  logic [WIDTH-1:0] high, high_d;
  logic [WIDTH-1:0] guess, guess_d;
  logic [WIDTH-1:0] result, result_d;
  logic             found, found_d;
  logic             err, err_d;
  logic             req, busy, done;
  logic [WIDTH:0]   mid;
  logic             one_hot;
  logic             last_probe;
  logic             expired;

  assign mid     = {1'b0, low} + {1'b0, high};
  assign one_hot = ({i_w_lt, i_w_gt, i_w_eq} == 3'b100)
                || ({i_w_lt, i_w_gt, i_w_eq} == 3'b010)
                || ({i_w_lt, i_w_gt, i_w_eq} == 3'b001);

  // Search ends on bad flags, a hit, or when the interval cannot shrink.
  assign last_probe = !one_hot || i_w_eq
                   || (i_w_lt && guess == MAXV)
                   || (i_w_gt && guess == '0);

`ifdef COMPARATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_d;

  assign expired = !i_w_ack && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt;
    if (state == S_CALC) begin
      cnt_d = '0;
    end else if (state == S_REQ && !i_w_ack) begin
      cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (i_w_start) state_nxt = S_CALC;
      end
      S_CALC: begin
        state_nxt = (low > high) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (i_w_ack) begin
          state_nxt = last_probe ? S_DONE : S_CALC;
        end else if (expired) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    low_d    = low;
    high_d   = high;
    guess_d  = guess;
    result_d = result;
    found_d  = found;
    err_d    = err;
    unique case (state)
      S_IDLE: begin
        if (i_w_start) begin
          low_d    = '0;
          high_d   = MAXV;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      S_CALC: begin
        if (low > high) begin
          found_d = 1'b0;
        end else begin
          guess_d = mid[WIDTH:1];
        end
      end
      S_REQ: begin
        if (i_w_ack) begin
          if (!one_hot) begin
            err_d   = 1'b1;
            found_d = 1'b0;
          end else if (i_w_eq) begin
            found_d  = 1'b1;
            result_d = guess;
          end else if (i_w_lt) begin
            if (guess != MAXV) low_d = guess + WIDTH'(1);
          end else begin
            if (guess != '0) high_d = guess - WIDTH'(1);
          end
        end else if (expired) begin
          err_d   = 1'b1;
          found_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      low    <= '0;
      high   <= MAXV;
      guess  <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
      req    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      low    <= low_d;
      high   <= high_d;
      guess  <= guess_d;
      result <= result_d;
      found  <= found_d;
      err    <= err_d;
      req    <= (state_nxt == S_REQ);
      busy   <= (state_nxt != S_IDLE);
      done   <= (state_nxt == S_DONE);
    end
  end

  assign o_w_req    = req;
  assign o_w_guess  = guess;
  assign o_w_busy   = busy;
  assign o_w_done   = done;
  assign o_w_found  = found;
  assign o_w_err    = err;
  assign o_w_result = result;

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Bench for comparator_search_ctrl: random targets against a
// reference binary search, plus error, reset and stall scenarios.
module tb_comparator_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       lt = 1'b0;
  logic       gt = 1'b0;
  logic       eq = 1'b0;
  logic       req;
  logic [7:0] guess;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [7:0] result;

  int n_vec = 0;
  int n_err = 0;

  comparator_search_ctrl #(.WIDTH(8), .TIMEOUT(16)) dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .i_w_start (start),
    .i_w_ack   (ack),
    .i_w_lt    (lt),
    .i_w_gt    (gt),
    .i_w_eq    (eq),
    .o_w_req   (req),
    .o_w_guess (guess),
    .o_w_busy  (busy),
    .o_w_done  (done),
    .o_w_found (found),
    .o_w_err   (err),
    .o_w_result(result)
  );

  always #5 clk = ~clk;

  task automatic check_idle_zero(input string name);
    n_vec++;
    if ({req, guess, busy, done, found, err, result} !== 21'd0) begin
      n_err++;
      $display("FAIL %s: outputs req=%b guess=%h busy=%b done=%b found=%b err=%b result=%h, all must be 0",
               name, req, guess, busy, done, found, err, result);
    end
  endtask

  // bad: 0 honest responder, 1 lt+gt on first ack, 2 no flag on first ack
  task automatic run_search(input logic [7:0] tgt, input int dmax,
                            input int bad, input bit noise, input string name);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] held;
    int lo, hi, g;
    int cyc, busy_n, done_n, wait_d, exp_busy, unstable;
    bit prev_req, fin;
    logic f_found, f_err;
    logic [7:0] f_result;

    lo = 0;
    hi = 255;
    while (lo <= hi) begin
      g = (lo + hi) / 2;
      exp_q.push_back(8'(g));
      if (bad != 0 || g == int'(tgt)) break;
      if (g < int'(tgt)) lo = g + 1;
      else hi = g - 1;
    end

    cyc = 0; busy_n = 0; done_n = 0; wait_d = 0;
    exp_busy = 1; unstable = 0; prev_req = 0; fin = 0;
    f_found = 0; f_err = 0; f_result = 0; held = 0;
    @(negedge clk);
    start = 1'b1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = noise && busy && !done && ($urandom_range(0, 1) == 1);
      ack = 1'b0;
      {lt, gt, eq} = noise ? 3'($urandom) : 3'b000;
      if (!req && noise) ack = 1'($urandom);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        fin = 1;
        f_found = found;
        f_err = err;
        f_result = result;
      end
      if (req) begin
        if (!prev_req) begin
          got_q.push_back(guess);
          held = guess;
          wait_d = (dmax > 0) ? int'($urandom_range(0, dmax)) : 0;
          exp_busy += wait_d + 2;
        end else if (guess !== held) begin
          unstable++;
        end
        if (wait_d == 0) begin
          ack = 1'b1;
          case (bad)
            1: {lt, gt, eq} = 3'b110;
            2: {lt, gt, eq} = 3'b000;
            default: {lt, gt, eq} = {guess < tgt, guess > tgt, guess == tgt};
          endcase
        end else begin
          wait_d--;
        end
      end
      prev_req = req;
    end
    start = 1'b0;
    ack = 1'b0;
    {lt, gt, eq} = 3'b000;

    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s probes: got %0d required %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s guess[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (f_found !== (bad == 0)) begin
      n_err++;
      $display("FAIL %s found: got %b required %b", name, f_found, bad == 0);
    end
    n_vec++;
    if (f_err !== (bad != 0)) begin
      n_err++;
      $display("FAIL %s err: got %b required %b", name, f_err, bad != 0);
    end
    n_vec++;
    if (f_result !== ((bad == 0) ? tgt : 8'h00)) begin
      n_err++;
      $display("FAIL %s result: got %h required %h", name, f_result,
               (bad == 0) ? tgt : 8'h00);
    end
    n_vec++;
    if (busy_n != exp_busy) begin
      n_err++;
      $display("FAIL %s busy cycles: got %0d required %0d", name, busy_n, exp_busy);
    end
    n_vec++;
    if (unstable != 0) begin
      n_err++;
      $display("FAIL %s guess stability: %0d changes while req required 0", name, unstable);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle after done: done=%b busy=%b required 0 0", name, done, busy);
    end
    n_vec++;
    if (found !== f_found || err !== f_err || result !== f_result) begin
      n_err++;
      $display("FAIL %s hold: found=%b err=%b result=%h required %b %b %h",
               name, found, err, result, f_found, f_err, f_result);
    end
    if (done_n != 1) begin
      n_err++;
      $display("FAIL %s done pulses: got %0d required 1", name, done_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset release");
  endtask

  task automatic test_directed();
    run_search(8'h5A, 0, 0, 0, "target_5a");
    run_search(8'hFF, 0, 0, 0, "target_ff");
    run_search(8'h00, 0, 0, 0, "target_00");
  endtask

  task automatic test_bad_flags();
    run_search(8'h33, 0, 1, 0, "lt_and_gt");
    run_search(8'h33, 0, 2, 0, "no_flag");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_search(8'($urandom), 3, 0, 1, "random");
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    while (!req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_vec++;
    if (req !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid req: got %b required 1", req);
    end
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_search(8'hC3, 2, 0, 0, "after_reset");
  endtask

  task automatic test_no_ack();
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef COMPARATOR_TIMEOUT_EN
    begin
      int cyc;
      logic f_err, f_found;
      cyc = 0;
      f_err = 0;
      f_found = 1;
      busy_n = 1;
      while (!done && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (busy) busy_n++;
        if (done) begin
          f_err = err;
          f_found = found;
        end
      end
      n_vec++;
      if (f_err !== 1'b1 || f_found !== 1'b0) begin
        n_err++;
        $display("FAIL timeout flags: err=%b found=%b required 1 0", f_err, f_found);
      end
      n_vec++;
      if (busy_n != 18) begin
        n_err++;
        $display("FAIL timeout busy cycles: got %0d required 18", busy_n);
      end
      @(negedge clk);
    end
`else
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    n_vec++;
    if (req !== 1'b1 || busy !== 1'b1 || busy_n != 100) begin
      n_err++;
      $display("FAIL stall: req=%b busy=%b busy_cycles=%0d required 1 1 100",
               req, busy, busy_n);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    run_search(8'h01, 0, 0, 0, "after_stall");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_flags();
    test_random();
    test_reset_mid();
    test_no_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
